// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter between the IF-stage fetch requester and the MEM-stage data requester.
// Optional one-entry fetch buffer enabled by defining ARB_FETCH_HOLD_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fetchReq,
  input  logic [31:0] i_fetchAddr,
  output logic [31:0] o_fetchInst,
  output logic        o_fetchValid,
  output logic        o_fetchStall,
  input  logic        i_dataReq,
  input  logic        i_dataWrite,
  input  logic [1:0]  i_dataSize,
  input  logic [31:0] i_dataAddr,
  input  logic [31:0] i_dataWData,
  output logic [31:0] o_dataRData,
  output logic        o_dataValid,
  output logic        o_dataStall,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [1:0]  o_memSize,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWData,
  input  logic        i_memReady,
  input  logic [31:0] i_memRData,
  output logic        o_timeout
);

  // state  | meaning
  // IDLE   | arbitrate between pending fetch and data requests
  // BUSY_I | fetch access on the memory port, waiting for ready
  // BUSY_D | data access on the memory port, waiting for ready
  // RESP   | one-cycle valid pulse to the requester just served
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0]  BURST_MAX = 4'(MAX_DATA_BURST);
  localparam logic [15:0] TMR_LOAD  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  state_t      state, state_nxt;
  logic [3:0]  burst, burst_nxt;
  logic [15:0] tmr;
  logic        resp_fetch;
  logic        data_win;
  logic        fetch_hit;
  logic        tmr_tc;

`ifdef ARB_FETCH_HOLD_EN
  logic        tag_valid;
  logic [31:0] tag_addr;
  logic [31:0] tag_inst;

  assign fetch_hit = tag_valid & (i_fetchAddr == tag_addr);
`else
  assign fetch_hit = 1'b0;
`endif

  // Data is the older instruction, so it wins unless fetch has waited out a full burst.
  assign data_win = i_dataReq & (~i_fetchReq | (burst < BURST_MAX));
  assign tmr_tc   = (tmr == 16'd0);

  assign o_fetchStall = i_fetchReq & ~o_fetchValid;
  assign o_dataStall  = i_dataReq & ~o_dataValid;

  always_comb begin
    state_nxt    = state;
    burst_nxt    = burst;
    o_memReq     = 1'b0;
    o_fetchValid = 1'b0;
    o_dataValid  = 1'b0;
    case (state)
      IDLE: begin
        if (data_win) begin
          state_nxt = BUSY_D;
          if (burst != BURST_MAX) burst_nxt = burst + 4'd1;
        end else if (i_fetchReq) begin
          state_nxt = fetch_hit ? RESP : BUSY_I;
          burst_nxt = 4'd0;
        end else begin
          burst_nxt = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        o_memReq = 1'b1;
        if (i_memReady | tmr_tc) state_nxt = RESP;
      end
      RESP: begin
        o_fetchValid = resp_fetch;
        o_dataValid  = ~resp_fetch;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst       <= 4'd0;
      tmr         <= 16'd0;
      resp_fetch  <= 1'b0;
      o_timeout   <= 1'b0;
      o_fetchInst <= 32'd0;
      o_dataRData <= 32'd0;
      o_memAddr   <= 32'd0;
      o_memWData  <= 32'd0;
      o_memWrite  <= 1'b0;
      o_memSize   <= 2'b00;
`ifdef ARB_FETCH_HOLD_EN
      tag_valid   <= 1'b0;
      tag_addr    <= 32'd0;
      tag_inst    <= 32'd0;
`endif
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
      case (state)
        IDLE: begin
          if (data_win) begin
            o_memAddr  <= i_dataAddr;
            o_memWrite <= i_dataWrite;
            o_memSize  <= i_dataSize;
            o_memWData <= i_dataWData;
            tmr        <= TMR_LOAD;
            resp_fetch <= 1'b0;
`ifdef ARB_FETCH_HOLD_EN
            if (i_dataWrite && (i_dataAddr[31:2] == tag_addr[31:2])) tag_valid <= 1'b0;
`endif
          end else if (i_fetchReq) begin
            resp_fetch <= 1'b1;
            if (!fetch_hit) begin
              o_memAddr  <= i_fetchAddr;
              o_memWrite <= 1'b0;
              o_memSize  <= 2'b10;
              o_memWData <= 32'd0;
              tmr        <= TMR_LOAD;
            end
`ifdef ARB_FETCH_HOLD_EN
            if (fetch_hit) o_fetchInst <= tag_inst;
`endif
          end
        end
        BUSY_I: begin
          if (i_memReady) begin
            o_fetchInst <= i_memRData;
`ifdef ARB_FETCH_HOLD_EN
            tag_valid   <= 1'b1;
            tag_addr    <= o_memAddr;
            tag_inst    <= i_memRData;
`endif
          end else if (tmr_tc) begin
            o_fetchInst <= NOP_INST;
            o_timeout   <= 1'b1;
`ifdef ARB_FETCH_HOLD_EN
            tag_valid   <= 1'b0;
`endif
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        BUSY_D: begin
          if (i_memReady) begin
            // Stores complete without touching the last load result.
            if (!o_memWrite) o_dataRData <= i_memRData;
          end else if (tmr_tc) begin
            o_dataRData <= 32'd0;
            o_timeout   <= 1'b1;
`ifdef ARB_FETCH_HOLD_EN
            tag_valid   <= 1'b0;
`endif
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table, hand-written corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_B = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fetchReq;
  logic [31:0] i_fetchAddr;
  logic [31:0] o_fetchInst;
  logic        o_fetchValid;
  logic        o_fetchStall;
  logic        i_dataReq;
  logic        i_dataWrite;
  logic [1:0]  i_dataSize;
  logic [31:0] i_dataAddr;
  logic [31:0] i_dataWData;
  logic [31:0] o_dataRData;
  logic        o_dataValid;
  logic        o_dataStall;
  logic        o_memReq;
  logic        o_memWrite;
  logic [1:0]  o_memSize;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWData;
  logic        i_memReady;
  logic [31:0] i_memRData;
  logic        o_timeout;

  mem_port_arbiter #(.MAX_DATA_BURST(MAX_B), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_fetchReq(i_fetchReq), .i_fetchAddr(i_fetchAddr), .o_fetchInst(o_fetchInst),
    .o_fetchValid(o_fetchValid), .o_fetchStall(o_fetchStall),
    .i_dataReq(i_dataReq), .i_dataWrite(i_dataWrite), .i_dataSize(i_dataSize),
    .i_dataAddr(i_dataAddr), .i_dataWData(i_dataWData), .o_dataRData(o_dataRData),
    .o_dataValid(o_dataValid), .o_dataStall(o_dataStall),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memSize(o_memSize),
    .o_memAddr(o_memAddr), .o_memWData(o_memWData),
    .i_memReady(i_memReady), .i_memRData(i_memRData), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] freq, faddr, dreq, dwr, daddr, wd, rdy, rdata;
    logic [31:0] e_req, e_wr, e_addr, e_wd, e_fv, e_dv, e_rd, e_fst, e_dst;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_g[6] = '{2, 2, 2, 2, 1, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_fetchReq = 1'b0; i_fetchAddr = '0; i_dataReq = 1'b0; i_dataWrite = 1'b0;
    i_dataSize = 2'b10; i_dataAddr = '0; i_dataWData = '0; i_memReady = 1'b0; i_memRData = '0;
  endtask

  // Leaves the bench one step after a clock edge with reset released; that cycle is IDLE.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Random-phase model: which requester owns the port and whether a response is due.
  int          m_phase, m_who, m_burst, wait_left;
  logic [31:0] m_addr, m_wd, exp_f, exp_d;
  logic        m_wr, exp_fv, exp_dv;
  logic [1:0]  m_size;
  int          ng, got, cnt;
  logic        seen;

  initial begin
    reset = 1'b1;
    clear_inputs();
    do_reset();

    @(negedge clk);
    chk("rst_memReq", {31'd0, o_memReq}, 32'd0);
    chk("rst_fetchValid", {31'd0, o_fetchValid}, 32'd0);
    chk("rst_dataValid", {31'd0, o_dataValid}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    chk("rst_fetchInst", o_fetchInst, 32'd0);
    chk("rst_dataRData", o_dataRData, 32'd0);
    chk("rst_memAddr", o_memAddr, 32'd0);
    chk("rst_memWData", o_memWData, 32'd0);

    // freq faddr dreq dwr daddr wd rdy rdata | e_req e_wr e_addr e_wd e_fv e_dv e_rd e_fst e_dst
    vq.push_back('{1,'h10000,0,0,0,0,0,0,            0,0,0,0,            0,0,0,          1,0});
    vq.push_back('{1,'h10000,0,0,0,0,1,'h93,         1,0,'h10000,0,      0,0,0,          1,0});
    vq.push_back('{1,'h10000,0,0,0,0,0,0,            0,0,0,0,            1,0,'h93,       0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,                  0,0,0,0,            0,0,0,          0,0});
    vq.push_back('{1,'h200,1,0,'h100,0,0,0,          0,0,0,0,            0,0,0,          1,1});
    vq.push_back('{1,'h200,1,0,'h100,0,0,0,          1,0,'h100,0,        0,0,0,          1,1});
    vq.push_back('{1,'h200,1,0,'h100,0,0,0,          1,0,'h100,0,        0,0,0,          1,1});
    vq.push_back('{1,'h200,1,0,'h100,0,1,'hAAAA5555, 1,0,'h100,0,        0,0,0,          1,1});
    vq.push_back('{1,'h200,1,0,'h100,0,0,0,          0,0,0,0,            0,1,'hAAAA5555, 1,0});
    vq.push_back('{1,'h200,0,0,0,0,0,0,              0,0,0,0,            0,0,0,          1,0});
    vq.push_back('{1,'h200,0,0,0,0,0,0,              1,0,'h200,0,        0,0,0,          1,0});
    vq.push_back('{1,'h200,0,0,0,0,1,'h00500113,     1,0,'h200,0,        0,0,0,          1,0});
    vq.push_back('{1,'h200,0,0,0,0,0,0,              0,0,0,0,            1,0,'h00500113, 0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,                  0,0,0,0,            0,0,0,          0,0});
    vq.push_back('{0,0,1,1,'h2000,'hDEADBEEF,0,0,    0,0,0,0,            0,0,0,          0,1});
    vq.push_back('{0,0,1,1,'h2000,'hDEADBEEF,0,0,    1,1,'h2000,'hDEADBEEF, 0,0,0,       0,1});
    vq.push_back('{0,0,1,1,'h2000,'hDEADBEEF,0,0,    1,1,'h2000,'hDEADBEEF, 0,0,0,       0,1});
    vq.push_back('{0,0,1,1,'h2000,'hDEADBEEF,1,'h55555555, 1,1,'h2000,'hDEADBEEF, 0,0,0, 0,1});
    vq.push_back('{0,0,1,1,'h2000,'hDEADBEEF,0,0,    0,0,0,0,            0,1,'hAAAA5555, 0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,                  0,0,0,0,            0,0,0,          0,0});

    foreach (vq[i]) begin
      @(posedge clk); #1;
      i_fetchReq = vq[i].freq[0]; i_fetchAddr = vq[i].faddr;
      i_dataReq = vq[i].dreq[0]; i_dataWrite = vq[i].dwr[0]; i_dataSize = 2'b10;
      i_dataAddr = vq[i].daddr; i_dataWData = vq[i].wd;
      i_memReady = vq[i].rdy[0]; i_memRData = vq[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_memReq", i), {31'd0, o_memReq}, vq[i].e_req);
      chk($sformatf("v%0d_fetchValid", i), {31'd0, o_fetchValid}, vq[i].e_fv);
      chk($sformatf("v%0d_dataValid", i), {31'd0, o_dataValid}, vq[i].e_dv);
      chk($sformatf("v%0d_fetchStall", i), {31'd0, o_fetchStall}, vq[i].e_fst);
      chk($sformatf("v%0d_dataStall", i), {31'd0, o_dataStall}, vq[i].e_dst);
      if (vq[i].e_req[0]) begin
        chk($sformatf("v%0d_memAddr", i), o_memAddr, vq[i].e_addr);
        chk($sformatf("v%0d_memWrite", i), {31'd0, o_memWrite}, vq[i].e_wr);
        chk($sformatf("v%0d_memSize", i), {30'd0, o_memSize}, 32'd2);
        if (vq[i].e_wr[0]) chk($sformatf("v%0d_memWData", i), o_memWData, vq[i].e_wd);
      end
      if (vq[i].e_fv[0]) chk($sformatf("v%0d_fetchInst", i), o_fetchInst, vq[i].e_rd);
      if (vq[i].e_dv[0]) chk($sformatf("v%0d_dataRData", i), o_dataRData, vq[i].e_rd);
    end

    // Data held continuously with fetch pending: four data grants, one fetch, then data again.
    do_reset();
    i_fetchReq = 1'b1; i_fetchAddr = 32'h400;
    i_dataReq = 1'b1; i_dataAddr = 32'h800; i_memReady = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (o_memReq) begin
        got = (o_memAddr == 32'h400) ? 1 : 2;
        chk($sformatf("burst_grant%0d", ng), got, exp_g[ng]);
        ng++;
      end
    end
    if (ng < 6) chk("burst_grant_count", ng, 6);

    // Memory never ready: fetch aborted after TMO busy cycles with a NOP.
    do_reset();
    i_fetchReq = 1'b1; i_fetchAddr = 32'h3000;
    cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (o_memReq) cnt++;
      else if (cnt > 0) begin
        seen = 1'b1;
        chk("tmo_busy_cycles", cnt, TMO);
        chk("tmo_fetchValid", {31'd0, o_fetchValid}, 32'd1);
        chk("tmo_fetchInst", o_fetchInst, 32'h0000_0013);
        chk("tmo_flag", {31'd0, o_timeout}, 32'd1);
      end
    end
    if (!seen) chk("tmo_seen", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_fetchReq = 1'b0;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {31'd0, o_timeout}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("tmo_cleared", {31'd0, o_timeout}, 32'd0);

    // Reset lands on a busy data access in the same cycle memory becomes ready.
    i_dataReq = 1'b1; i_dataAddr = 32'h4000;
    @(posedge clk); #1;
    reset = 1'b1; i_memReady = 1'b1; i_memRData = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("rstbusy_memReq_before", {31'd0, o_memReq}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; i_dataReq = 1'b0; i_memReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstbusy_memReq%0d", c), {31'd0, o_memReq}, 32'd0);
      chk($sformatf("rstbusy_dataValid%0d", c), {31'd0, o_dataValid}, 32'd0);
    end
    chk("rstbusy_dataRData", o_dataRData, 32'd0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_phase = 0; m_who = 0; m_burst = 0; wait_left = 0;
    exp_f = '0; exp_d = '0; m_addr = '0; m_wd = '0; m_wr = 1'b0; m_size = 2'b00;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (!i_fetchReq && $urandom_range(0, 2) == 0) begin
        i_fetchReq = 1'b1; i_fetchAddr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!i_dataReq && $urandom_range(0, 2) == 0) begin
        i_dataReq = 1'b1; i_dataWrite = 1'($urandom_range(0, 1));
        i_dataSize = 2'($urandom_range(0, 3)); i_dataAddr = $urandom(); i_dataWData = $urandom();
      end
      i_memRData = $urandom();
      if (m_phase == 1) i_memReady = (wait_left == 0);
      else i_memReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_fv = (m_phase == 2) && (m_who == 1);
      exp_dv = (m_phase == 2) && (m_who == 2);
      chk("rnd_memReq", {31'd0, o_memReq}, {31'd0, m_phase == 1});
      chk("rnd_fetchValid", {31'd0, o_fetchValid}, {31'd0, exp_fv});
      chk("rnd_dataValid", {31'd0, o_dataValid}, {31'd0, exp_dv});
      chk("rnd_fetchStall", {31'd0, o_fetchStall}, {31'd0, i_fetchReq & ~exp_fv});
      chk("rnd_dataStall", {31'd0, o_dataStall}, {31'd0, i_dataReq & ~exp_dv});
      if (m_phase == 1) begin
        chk("rnd_memAddr", o_memAddr, m_addr);
        chk("rnd_memWrite", {31'd0, o_memWrite}, {31'd0, m_wr});
        chk("rnd_memSize", {30'd0, o_memSize}, {30'd0, m_size});
        if (m_wr) chk("rnd_memWData", o_memWData, m_wd);
      end
      if (exp_fv) chk("rnd_fetchInst", o_fetchInst, exp_f);
      if (exp_dv) chk("rnd_dataRData", o_dataRData, exp_d);
      case (m_phase)
        0: begin
          if (i_dataReq && (!i_fetchReq || m_burst < MAX_B)) begin
            m_who = 2; m_burst++; m_phase = 1; wait_left = $urandom_range(0, 3);
            m_addr = i_dataAddr; m_wr = i_dataWrite; m_size = i_dataSize; m_wd = i_dataWData;
          end else if (i_fetchReq) begin
            m_who = 1; m_burst = 0; m_phase = 1; wait_left = $urandom_range(0, 3);
            m_addr = i_fetchAddr; m_wr = 1'b0; m_size = 2'b10;
          end else begin
            m_burst = 0;
          end
        end
        1: begin
          if (i_memReady) begin
            m_phase = 2;
            if (m_who == 1) exp_f = i_memRData;
            else if (!m_wr) exp_d = i_memRData;
          end else begin
            wait_left--;
          end
        end
        default: begin
          m_phase = 0;
          if (m_who == 1) i_fetchReq = 1'b0;
          else i_dataReq = 1'b0;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
